// File: rtl/ysyx_22041412_axi_rw_sched_pkg.sv
// Shared types and constants for the AXI read/write scheduler.
//   r_state_e : read FSM encoding (idle / IF burst / MEM burst)
//   w_state_e : write FSM encoding (idle / busy)
//   BURST_8   : AXI size for 8-byte beats, used for every read grant
//   LINE_OFF_DEF : default cache-line offset width for the store-to-load hazard compare
package ysyx_22041412_axi_pkg;

  typedef enum logic [1:0] {
    RIdle,
    RIf,
    RMem
  } r_state_e;

  typedef enum logic {
    WIdle,
    WBusy
  } w_state_e;

  localparam logic [2:0] BURST_8 = 3'b011;
  localparam int unsigned LINE_OFF_DEF = 6;

endpackage

// File: rtl/ysyx_22041412_axi_rw_sched_if.sv
// Bus bundle between the core requesters, the scheduler and the AXI master.
//   if_r_*  : IF fetch read request and returned beats
//   mem_r_* : MEM load read request and returned beats
//   mem_w_* : MEM store write request, write data and beat acceptance
//   r_*     : read request to the AXI master and beats coming back
//   w_*     : write request to the AXI master and beat acceptance
// Modports:
//   master : the surroundings (core requesters plus AXI master) that drive the scheduler
//   slave  : the scheduler itself
interface ysyx_22041412_axi_rw_sched_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);

  logic              if_r_valid;
  logic [ADDR_W-1:0] if_r_addr;
  logic [7:0]        if_r_len;
  logic              if_r_ready;
  logic [DATA_W-1:0] if_r_data;
  logic              if_r_last;

  logic              mem_r_valid;
  logic [ADDR_W-1:0] mem_r_addr;
  logic [7:0]        mem_r_len;
  logic              mem_r_ready;
  logic [DATA_W-1:0] mem_r_data;
  logic              mem_r_last;

  logic              mem_w_valid;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [7:0]        mem_w_len;
  logic [2:0]        mem_w_size;
  logic [DATA_W-1:0] mem_w_data;
  logic              mem_w_ready;
  logic              mem_w_last;

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [2:0]        r_size;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  logic              w_valid;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len;
  logic [2:0]        w_size;
  logic [DATA_W-1:0] w_data;
  logic              w_ready;
  logic              w_last;

  modport master (
    output if_r_valid, if_r_addr, if_r_len,
    input  if_r_ready, if_r_data, if_r_last,
    output mem_r_valid, mem_r_addr, mem_r_len,
    input  mem_r_ready, mem_r_data, mem_r_last,
    output mem_w_valid, mem_w_addr, mem_w_len, mem_w_size, mem_w_data,
    input  mem_w_ready, mem_w_last,
    input  r_valid, r_addr, r_len, r_size,
    output r_ready, r_data, r_last,
    input  w_valid, w_addr, w_len, w_size, w_data,
    output w_ready, w_last
  );

  modport slave (
    input  if_r_valid, if_r_addr, if_r_len,
    output if_r_ready, if_r_data, if_r_last,
    input  mem_r_valid, mem_r_addr, mem_r_len,
    output mem_r_ready, mem_r_data, mem_r_last,
    input  mem_w_valid, mem_w_addr, mem_w_len, mem_w_size, mem_w_data,
    output mem_w_ready, mem_w_last,
    output r_valid, r_addr, r_len, r_size,
    input  r_ready, r_data, r_last,
    output w_valid, w_addr, w_len, w_size, w_data,
    input  w_ready, w_last
  );

endinterface

// File: rtl/ysyx_22041412_rd_grant.sv
// Read-channel grant decision with a starvation counter.
//   clk, rst     : clock, asynchronous active-low reset
//   idle         : read FSM is idle, grants only issue then
//   if_r_valid   : IF read pending
//   mem_r_valid  : MEM read pending
//   hazard       : MEM read targets a line with an outstanding write
//   grant_if/mem : one-cycle grant pulses, mutually exclusive
// MEM normally wins; after STARVE_MAX consecutive MEM grants while IF waits, IF is forced in.
module ysyx_22041412_rd_grant #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_r_valid,
  input  logic mem_r_valid,
  input  logic hazard,
  output logic grant_if,
  output logic grant_mem
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_q, starve_d;
  logic            starve_full;

  assign starve_full = (starve_q == CntW'(STARVE_MAX));

  always_comb begin
    grant_mem = idle & mem_r_valid & ~hazard & ~(starve_full & if_r_valid);
    grant_if  = idle & if_r_valid & ~grant_mem;
  end

  // Count only MEM grants that actually made IF wait; any other grant resets the streak.
  always_comb begin
    starve_d = starve_q;
    if (grant_mem && if_r_valid) begin
      if (!starve_full) starve_d = starve_q + CntW'(1);
    end else if (grant_mem || grant_if) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

endmodule

// File: rtl/ysyx_22041412_axi_rw_sched.sv
// Read/write scheduler between the core's memory requesters and the AXI master.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : scheduler view of the request/beat bundle (see the interface file)
// Reads: IF and MEM arbitrated by ysyx_22041412_rd_grant, request latched at grant and held
// until the last beat. Writes: single outstanding burst, latched at acceptance. A MEM read
// to the same cache line as an outstanding or incoming write waits for the write to finish.
module ysyx_22041412_axi_rw_sched
  import ysyx_22041412_axi_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned LINE_OFF   = LINE_OFF_DEF
) (
  input logic                         clk,
  input logic                         rst,
  ysyx_22041412_axi_rw_sched_if.slave bus
);

  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;

  logic [ADDR_W-1:0] r_addr_q, w_addr_q;
  logic [7:0]        r_len_q, w_len_q;
  logic [2:0]        r_size_q, w_size_q;
  logic [DATA_W-1:0] w_data_gated;

  logic w_busy, hazard, grant_if, grant_mem, r_done, w_done;

  assign w_busy = (w_state_q == WBusy);
  assign r_done = bus.r_ready & bus.r_last;
  assign w_done = bus.w_ready & bus.w_last;

  // Check both the latched write and a write being accepted this cycle, so that a
  // same-cycle write and read to one line resolves in favour of the write.
  assign hazard = bus.mem_r_valid &
                  ((w_busy &
                    (bus.mem_r_addr[ADDR_W-1:LINE_OFF] == w_addr_q[ADDR_W-1:LINE_OFF])) |
                   (bus.mem_w_valid &
                    (bus.mem_r_addr[ADDR_W-1:LINE_OFF] == bus.mem_w_addr[ADDR_W-1:LINE_OFF])));

  ysyx_22041412_rd_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_rd_grant (
    .clk         (clk),
    .rst         (rst),
    .idle        (r_state_q == RIdle),
    .if_r_valid  (bus.if_r_valid),
    .mem_r_valid (bus.mem_r_valid),
    .hazard      (hazard),
    .grant_if    (grant_if),
    .grant_mem   (grant_mem)
  );

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= RIdle;
      w_state_q <= WIdle;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle: begin
        if (grant_mem)     r_state_d = RMem;
        else if (grant_if) r_state_d = RIf;
      end
      RIf, RMem: if (r_done) r_state_d = RIdle;
      default:   r_state_d = RIdle;
    endcase

    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (bus.mem_w_valid) w_state_d = WBusy;
      WBusy:   if (w_done) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  // Request attributes, frozen for the duration of each burst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_q <= '0;
      r_len_q  <= '0;
      r_size_q <= '0;
      w_addr_q <= '0;
      w_len_q  <= '0;
      w_size_q <= '0;
    end else begin
      if (grant_mem) begin
        r_addr_q <= bus.mem_r_addr;
        r_len_q  <= bus.mem_r_len;
        r_size_q <= BURST_8;
      end else if (grant_if) begin
        r_addr_q <= bus.if_r_addr;
        r_len_q  <= bus.if_r_len;
        r_size_q <= BURST_8;
      end
      if (!w_busy && bus.mem_w_valid) begin
        w_addr_q <= bus.mem_w_addr;
        w_len_q  <= bus.mem_w_len;
        w_size_q <= bus.mem_w_size;
      end
    end
  end

  // Outputs and beat routing
  always_comb begin
    bus.r_valid     = 1'b0;
    bus.if_r_ready  = 1'b0;
    bus.if_r_data   = '0;
    bus.if_r_last   = 1'b0;
    bus.mem_r_ready = 1'b0;
    bus.mem_r_data  = '0;
    bus.mem_r_last  = 1'b0;
    unique case (r_state_q)
      RIf: begin
        bus.r_valid    = 1'b1;
        bus.if_r_ready = bus.r_ready;
        bus.if_r_data  = bus.r_data;
        bus.if_r_last  = bus.r_last;
      end
      RMem: begin
        bus.r_valid     = 1'b1;
        bus.mem_r_ready = bus.r_ready;
        bus.mem_r_data  = bus.r_data;
        bus.mem_r_last  = bus.r_last;
      end
      default: ;
    endcase

    bus.w_valid     = w_busy;
    bus.mem_w_ready = w_busy & bus.w_ready;
    bus.mem_w_last  = w_busy & bus.w_last;
    w_data_gated    = w_busy ? bus.mem_w_data : '0;
  end

  assign bus.r_addr = r_addr_q;
  assign bus.r_len  = r_len_q;
  assign bus.r_size = r_size_q;
  assign bus.w_addr = w_addr_q;
  assign bus.w_len  = w_len_q;
  assign bus.w_size = w_size_q;
  assign bus.w_data = w_data_gated;

endmodule

// File: tb/tb_ysyx_22041412_axi_rw_sched.sv
// Directed bench for the AXI read/write scheduler: IF-only burst, MEM/IF priority, starvation
// limit, reset mid-burst, store-to-load line hazard and write beat sequencing.
module tb_ysyx_22041412_axi_rw_sched;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ysyx_22041412_axi_rw_sched_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  ysyx_22041412_axi_rw_sched #(
    .ADDR_W     (32),
    .DATA_W     (64),
    .STARVE_MAX (4),
    .LINE_OFF   (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One read beat from the AXI master; checks it reaches only the granted requester.
  task automatic rd_beat(input bit to_mem, input bit last, input logic [63:0] d);
    bus.r_ready = 1'b1;
    bus.r_data  = d;
    bus.r_last  = last;
    #1;
    if (to_mem) begin
      chk("mem_r_ready", bus.mem_r_ready, 64'd1);
      chk("mem_r_data", bus.mem_r_data, d);
      chk("mem_r_last", bus.mem_r_last, {63'd0, last});
      chk("if_r_ready_off", bus.if_r_ready, 64'd0);
      chk("if_r_data_off", bus.if_r_data, 64'd0);
    end else begin
      chk("if_r_ready", bus.if_r_ready, 64'd1);
      chk("if_r_data", bus.if_r_data, d);
      chk("if_r_last", bus.if_r_last, {63'd0, last});
      chk("mem_r_ready_off", bus.mem_r_ready, 64'd0);
      chk("mem_r_data_off", bus.mem_r_data, 64'd0);
    end
    step();
    bus.r_ready = 1'b0;
    bus.r_data  = '0;
    bus.r_last  = 1'b0;
  endtask

  // Expect a grant at the next edge, run a single-beat burst, expect the bubble after it.
  task automatic rd_grant_one(input string tag, input logic [31:0] addr, input bit to_mem);
    step();
    chk({tag, "_r_valid"}, bus.r_valid, 64'd1);
    chk({tag, "_r_addr"}, bus.r_addr, {32'd0, addr});
    rd_beat(to_mem, 1'b1, {32'hD00D_0000, addr});
    #1;
    chk({tag, "_r_valid_drop"}, bus.r_valid, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.if_r_valid  = 0; bus.if_r_addr  = '0; bus.if_r_len  = '0;
    bus.mem_r_valid = 0; bus.mem_r_addr = '0; bus.mem_r_len = '0;
    bus.mem_w_valid = 0; bus.mem_w_addr = '0; bus.mem_w_len = '0;
    bus.mem_w_size  = '0; bus.mem_w_data = '0;
    bus.r_ready = 0; bus.r_data = '0; bus.r_last = 0;
    bus.w_ready = 0; bus.w_last = 0;
    #1 rst = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_r_valid", bus.r_valid, 64'd0);
    chk("rst_w_valid", bus.w_valid, 64'd0);
    chk("rst_r_addr", bus.r_addr, 64'd0);
    chk("rst_r_size", bus.r_size, 64'd0);
    chk("rst_w_addr", bus.w_addr, 64'd0);
    chk("rst_w_size", bus.w_size, 64'd0);
    chk("rst_mem_w_ready", bus.mem_w_ready, 64'd0);
    rst = 1'b1;

    // IF only, 4-beat burst
    bus.if_r_valid = 1; bus.if_r_addr = 32'h8000_0000; bus.if_r_len = 8'd3;
    #1 chk("t1_no_grant_yet", bus.r_valid, 64'd0);
    step();
    chk("t1_r_valid", bus.r_valid, 64'd1);
    chk("t1_r_addr", bus.r_addr, 64'h8000_0000);
    chk("t1_r_len", bus.r_len, 64'd3);
    chk("t1_r_size", bus.r_size, 64'd3);
    for (int i = 0; i < 4; i++) rd_beat(1'b0, (i == 3), 64'h100 + 64'(i));
    bus.if_r_valid = 0;
    #1 chk("t1_r_valid_drop", bus.r_valid, 64'd0);

    // Both request together: MEM first, IF after one bubble
    bus.if_r_valid  = 1; bus.if_r_addr  = 32'h8000_0100; bus.if_r_len  = 8'd0;
    bus.mem_r_valid = 1; bus.mem_r_addr = 32'h8000_0200; bus.mem_r_len = 8'd0;
    rd_grant_one("t2_mem", 32'h8000_0200, 1'b1);
    bus.mem_r_valid = 0;
    rd_grant_one("t2_if", 32'h8000_0100, 1'b0);
    bus.if_r_valid = 0;

    // Starvation: 4 MEM grants, then IF, then the streak restarts from zero
    bus.if_r_valid  = 1; bus.if_r_addr  = 32'h8000_0300;
    bus.mem_r_valid = 1; bus.mem_r_addr = 32'h8000_0400;
    for (int i = 0; i < 4; i++) rd_grant_one("t3_mem", 32'h8000_0400, 1'b1);
    rd_grant_one("t3_if5", 32'h8000_0300, 1'b0);
    for (int i = 0; i < 4; i++) rd_grant_one("t3_mem_again", 32'h8000_0400, 1'b1);

    // Streak is at the limit, so IF wins; a write starts alongside; reset mid-burst
    bus.if_r_addr = 32'h8000_1000; bus.if_r_len = 8'd3;
    bus.mem_w_valid = 1; bus.mem_w_addr = 32'h8000_3000;
    bus.mem_w_len = 8'd1; bus.mem_w_size = 3'b011;
    step();
    chk("t6_r_valid", bus.r_valid, 64'd1);
    chk("t6_r_addr_if", bus.r_addr, 64'h8000_1000);
    chk("t6_w_valid", bus.w_valid, 64'd1);
    bus.r_ready = 1; bus.r_data = 64'h55;
    #1 chk("t6_if_r_ready", bus.if_r_ready, 64'd1);
    rst = 1'b0;
    #1;
    chk("t6_rst_r_valid", bus.r_valid, 64'd0);
    chk("t6_rst_w_valid", bus.w_valid, 64'd0);
    chk("t6_rst_if_r_ready", bus.if_r_ready, 64'd0);
    chk("t6_rst_if_r_data", bus.if_r_data, 64'd0);
    chk("t6_rst_r_addr", bus.r_addr, 64'd0);
    chk("t6_rst_r_len", bus.r_len, 64'd0);
    chk("t6_rst_w_addr", bus.w_addr, 64'd0);
    bus.r_ready = 0; bus.r_data = '0; bus.mem_w_valid = 0;
    step();
    rst = 1'b1;
    // Starve counter cleared by reset: MEM wins again
    step();
    chk("t6_post_r_valid", bus.r_valid, 64'd1);
    chk("t6_post_r_addr_mem", bus.r_addr, 64'h8000_0400);
    chk("t6_post_w_valid", bus.w_valid, 64'd0);
    rd_beat(1'b1, 1'b1, 64'h77);
    bus.mem_r_valid = 0;
    rd_grant_one("t6_post_if", 32'h8000_1000, 1'b0);
    bus.if_r_valid = 0;

    // Write to line 0x40 with concurrent read to another line
    bus.mem_w_valid = 1; bus.mem_w_addr = 32'h8000_0040;
    bus.mem_w_len = 8'd1; bus.mem_w_size = 3'b011;
    bus.mem_r_valid = 1; bus.mem_r_addr = 32'h8000_0080; bus.mem_r_len = 8'd0;
    #1 chk("t4_w_valid_pre", bus.w_valid, 64'd0);
    step();
    chk("t4_w_valid", bus.w_valid, 64'd1);
    chk("t4_w_addr", bus.w_addr, 64'h8000_0040);
    chk("t4_w_len", bus.w_len, 64'd1);
    chk("t4_w_size", bus.w_size, 64'd3);
    chk("t4_r_valid_concurrent", bus.r_valid, 64'd1);
    chk("t4_r_addr_concurrent", bus.r_addr, 64'h8000_0080);
    chk("t4_mem_w_ready_low", bus.mem_w_ready, 64'd0);
    rd_beat(1'b1, 1'b1, 64'hABC);
    // Same-line read must wait for the write
    bus.mem_r_addr = 32'h8000_0058;
    #1 chk("t4_r_idle", bus.r_valid, 64'd0);
    step();
    chk("t4_r_held1", bus.r_valid, 64'd0);
    bus.w_ready = 1; bus.w_last = 0; bus.mem_w_data = 64'hAAAA;
    #1;
    chk("t5_mem_w_ready_b1", bus.mem_w_ready, 64'd1);
    chk("t5_mem_w_last_b1", bus.mem_w_last, 64'd0);
    chk("t5_w_data_b1", bus.w_data, 64'hAAAA);
    step();
    bus.w_last = 1; bus.mem_w_data = 64'hBBBB;
    #1;
    chk("t5_mem_w_last_b2", bus.mem_w_last, 64'd1);
    chk("t5_w_data_b2", bus.w_data, 64'hBBBB);
    chk("t4_r_held2", bus.r_valid, 64'd0);
    step();
    bus.mem_w_valid = 0; bus.w_ready = 0; bus.w_last = 0;
    #1;
    chk("t5_w_valid_drop", bus.w_valid, 64'd0);
    chk("t5_mem_w_ready_idle", bus.mem_w_ready, 64'd0);
    chk("t4_r_held3", bus.r_valid, 64'd0);
    step();
    chk("t4_r_valid_release", bus.r_valid, 64'd1);
    chk("t4_r_addr_release", bus.r_addr, 64'h8000_0058);
    rd_beat(1'b1, 1'b1, 64'h58);
    bus.mem_r_valid = 0;
    #1 chk("t4_r_valid_drop", bus.r_valid, 64'd0);

    // Same-cycle write and read to one line: write wins
    bus.mem_w_valid = 1; bus.mem_w_addr = 32'h8000_0500; bus.mem_w_len = 8'd0;
    bus.mem_r_valid = 1; bus.mem_r_addr = 32'h8000_0510;
    step();
    chk("t7_w_valid", bus.w_valid, 64'd1);
    chk("t7_r_blocked", bus.r_valid, 64'd0);
    bus.w_ready = 1; bus.w_last = 1;
    step();
    bus.mem_w_valid = 0; bus.w_ready = 0; bus.w_last = 0;
    #1 chk("t7_r_still_blocked", bus.r_valid, 64'd0);
    rd_grant_one("t7_r_after_write", 32'h8000_0510, 1'b1);
    bus.mem_r_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22041412_axi_rw_sched.md
# ysyx_22041412_axi_rw_sched

Read/write scheduler between the core's memory requesters (IF fetch, MEM load, MEM store) and the AXI master's request interface. Arbitrates the read channel between IF and MEM with MEM priority bounded by a starvation limit, sequences the write channel, and enforces store-to-load ordering: a MEM read to a cache line with an outstanding write is held back. Request attributes are latched at grant so the AXI master sees stable address, length and size for the whole burst.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width
- STARVE_MAX, 4, consecutive MEM-read grants allowed while IF waits
- LINE_OFF, 6, line offset bits for the hazard compare (compare addr[ADDR_W-1:LINE_OFF])
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- if_r_valid / if_r_addr / if_r_len  in  1/ADDR_W/8  IF read request, held until last beat
- if_r_ready / if_r_data / if_r_last  out  1/DATA_W/1  IF beat strobe, data, last
- mem_r_valid / mem_r_addr / mem_r_len  in  1/ADDR_W/8  MEM read request
- mem_r_ready / mem_r_data / mem_r_last  out  1/DATA_W/1  MEM read beat
- mem_w_valid / mem_w_addr / mem_w_len / mem_w_size  in  1/ADDR_W/8/3  MEM write request
- mem_w_data  in  DATA_W  current write beat
- mem_w_ready / mem_w_last  out  1/1  write beat accepted, final beat
- r_valid / r_addr / r_len / r_size  out  1/ADDR_W/8/3  read request to AXI master
- r_ready / r_data / r_last  in  1/DATA_W/1  read beat from AXI master
- w_valid / w_addr / w_len / w_size / w_data  out  1/ADDR_W/8/3/DATA_W  write request
- w_ready / w_last  in  1/1  write beat accepted, final beat

## Operation
- Read FSM: R_IDLE, R_IF, R_MEM. Write FSM: W_IDLE, W_BUSY. Independent; may run concurrently.
- R_IDLE grant (evaluated each cycle): hazard = mem_r_valid & write outstanding (W_BUSY, or mem_w_valid) & line(mem_r_addr)==line(write addr, latched or incoming).
  - MEM eligible = mem_r_valid & ~hazard & ~(starve==STARVE_MAX & if_r_valid).
  - MEM eligible -> R_MEM; else if_r_valid -> R_IF; else stay.
- On grant latch addr/len into r_addr/r_len; r_size = 3'b011 for every grant.
- starve: +1 on R_MEM grant while if_r_valid high (saturates at STARVE_MAX); cleared on R_IF grant or when if_r_valid low at a grant.
- R_IF/R_MEM: route r_ready/r_data/r_last to the granted requester only; other requester sees ready=0, last=0, data=0. Leave to R_IDLE on r_ready & r_last. Requester dropping valid mid-burst is ignored: grant held until last beat.
- W_IDLE -> W_BUSY on mem_w_valid; latch addr/len/size. w_data combinational from mem_w_data. mem_w_ready=w_ready, mem_w_last=w_last in W_BUSY, else 0. W_BUSY -> W_IDLE on w_ready & w_last.
- Simultaneous write and MEM read to same line in R_IDLE: write wins, read waits until write FSM returns to W_IDLE.

## Timing
- Reset (rst low, async): both FSMs idle, starve=0, all outputs 0 (r_valid, w_valid, latched addr/len/size, all ready/last/data).
- Grant latency: request sampled in cycle N, r_valid/w_valid high from N+1 (registered).
- r_valid low the cycle after the last-beat handshake; next grant earliest that cycle, so one bubble cycle between read bursts; same for writes.
- Beat routing combinational: zero added latency per beat.
- Hazard release: read may be granted in the cycle the write FSM is back in W_IDLE (same cycle mem_w_valid is low).
- Reset mid-burst: outputs drop immediately; no burst resumed after reset.

## Structure
- Package ysyx_22041412_axi_pkg: read/write state encodings, BURST_8 size constant (3'b011), default LINE_OFF.
- One sub-module: ysyx_22041412_rd_grant (grant decision + starvation counter); FSMs and routing stay in the top.

## Test plan
- IF only: if_r_valid, addr 0x8000_0000, len 3 -> r_valid cycle N+1, r_addr 0x8000_0000, r_size 3'b011, 4 beats on if_r_*, if_r_last on beat 4, r_valid low next cycle.
- Both read requests same cycle -> MEM granted first; IF granted one bubble after MEM's last beat.
- MEM reads back-to-back with IF pending, STARVE_MAX=4 -> 4 MEM grants, 5th grant to IF, starve reset to 0.
- MEM write to 0x8000_0040 busy, MEM read 0x8000_0058 -> read held until W_IDLE; read 0x8000_0080 granted concurrently with the write.
- Write len 1 -> w_valid N+1, mem_w_ready follows w_ready, mem_w_last on beat 2, W_IDLE next cycle.
- Assert rst low mid-read burst -> all outputs 0 same cycle; after release IF request granted normally with starve=0.
